cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 89 ++++++++
 tb/tb_cpu_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer with PC and instruction register
// Ports:
//   i_clk, i_reset                    clock, synchronous active-high reset
//   o_imem_request, i_imem_ready      instruction fetch handshake; i_imem_data is the fetched word
//   o_pc, o_instruction               current PC and instruction register (held stable DECODE..WRITEBACK)
//   i_branch_condition, i_immediate   decoder control-flow info
//   i_destination_register_write_enable, i_memory_write_enable, i_illegal   decoder flags
//   i_alu_zero                        ALU result equals zero
//   o_dmem_request, i_dmem_ready      store handshake
//   o_register_write_enable           gated register file write strobe
//   o_writeback_select                0 = ALU result, 1 = PC+4 link
//   o_retired, o_halted               retire pulse, sticky halt flag
package cpu_sequencer_pkg;
    typedef enum logic [1:0] {BRANCH_NONE, BRANCH_JUMP, BRANCH_NE} t_branch_condition;
endpackage

module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_imem_request,
    input  logic              i_imem_ready,
    input  logic [31:0]       i_imem_data,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_instruction,
    input  t_branch_condition i_branch_condition,
    input  logic [31:0]       i_immediate,
    input  logic              i_destination_register_write_enable,
    input  logic              i_memory_write_enable,
    input  logic              i_illegal,
    input  logic              i_alu_zero,
    output logic              o_dmem_request,
    input  logic              i_dmem_ready,
    output logic              o_register_write_enable,
    output logic              o_writeback_select,
    output logic              o_retired,
    output logic              o_halted
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} t_state;

    t_state      state, state_next;
    logic [31:0] pc, ir, next_pc, target;
    logic        taken, aligned, commit;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= NOP;
            next_pc <= RESET_PC;
        end else begin
            state <= state_next;
            if (state == FETCH && i_imem_ready) ir <= i_imem_data;
            if (state == EXECUTE) next_pc <= target;
            if (commit) pc <= next_pc;
        end
    end

    always_comb begin
        taken      = i_branch_condition == BRANCH_JUMP || (i_branch_condition == BRANCH_NE && !i_alu_zero);
        target     = pc + (taken ? i_immediate : 32'd4);
        aligned    = next_pc[1:0] == 2'b00;
        // a misaligned target never commits: PC stays put and the core halts instead
        commit     = state == WRITEBACK && aligned;
        state_next = state;
        case (state)
            FETCH:     state_next = i_imem_ready ? DECODE : FETCH;
            DECODE:    state_next = i_illegal ? HALT : EXECUTE;
            EXECUTE:   state_next = i_memory_write_enable ? MEMORY : WRITEBACK;
            MEMORY:    state_next = i_dmem_ready ? WRITEBACK : MEMORY;
            WRITEBACK: state_next = aligned ? FETCH : HALT;
            default:   state_next = HALT;
        endcase
    end

    assign o_imem_request          = state == FETCH;
    assign o_dmem_request          = state == MEMORY;
    assign o_retired               = commit;
    assign o_register_write_enable = commit && i_destination_register_write_enable;
    assign o_writeback_select      = state == WRITEBACK && i_branch_condition == BRANCH_JUMP;
    assign o_halted                = state == HALT;
    assign o_pc                    = pc;
    assign o_instruction           = ir;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] ADD2 = 32'h00a0_0113;
    localparam logic [31:0] SW   = 32'h0011_2023;
    localparam logic [31:0] BNE  = 32'hfe00_1ce3;
    localparam logic [31:0] JAL  = 32'h1000_00ef;
    localparam logic [31:0] BAD  = 32'hffff_ffff;

    logic              i_clk = 1'b0, i_reset = 1'b1, i_imem_ready = 1'b0, i_dmem_ready = 1'b0;
    logic [31:0]       i_imem_data = 32'h0, i_immediate = 32'h0;
    t_branch_condition i_branch_condition = BRANCH_NONE;
    logic              i_destination_register_write_enable = 1'b0, i_memory_write_enable = 1'b0;
    logic              i_illegal = 1'b0, i_alu_zero = 1'b0;
    logic              o_imem_request, o_dmem_request, o_register_write_enable, o_writeback_select;
    logic              o_retired, o_halted;
    logic [31:0]       o_pc, o_instruction;

    always #5 i_clk = ~i_clk;

    cpu_sequencer dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .o_imem_request(o_imem_request), .i_imem_ready(i_imem_ready), .i_imem_data(i_imem_data),
        .o_pc(o_pc), .o_instruction(o_instruction),
        .i_branch_condition(i_branch_condition), .i_immediate(i_immediate),
        .i_destination_register_write_enable(i_destination_register_write_enable),
        .i_memory_write_enable(i_memory_write_enable), .i_illegal(i_illegal), .i_alu_zero(i_alu_zero),
        .o_dmem_request(o_dmem_request), .i_dmem_ready(i_dmem_ready),
        .o_register_write_enable(o_register_write_enable), .o_writeback_select(o_writeback_select),
        .o_retired(o_retired), .o_halted(o_halted)
    );

    typedef struct {
        logic [31:0]       instr;
        t_branch_condition br;
        logic [31:0]       imm;
        logic              we, mwe, ill, zero;
        int                iw, dw;
    } stim_t;

    typedef struct {
        int          cyc, nret, ireq, dreq;
        logic        rwe, wbs, halted;
        logic [31:0] pc, ir, ir0;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic stim_t mk(input logic [31:0] instr, input t_branch_condition br, input logic [31:0] imm,
                                 input logic we, input logic mwe, input logic ill, input logic zero,
                                 input int iw, input int dw);
        stim_t s;
        s.instr = instr; s.br = br; s.imm = imm; s.we = we; s.mwe = mwe;
        s.ill = ill; s.zero = zero; s.iw = iw; s.dw = dw;
        return s;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // reset held with both readies high so a ready during reset must be ignored
    task automatic do_reset();
        i_reset = 1'b1; i_imem_ready = 1'b1; i_dmem_ready = 1'b1; i_imem_data = 32'hdead_beef;
        step();
        step();
        i_reset = 1'b0; i_imem_ready = 1'b0; i_dmem_ready = 1'b0;
    endtask

    // drives one instruction from its FETCH cycle (cycle 1) until retire or halt, observing only
    task automatic run_instr(input stim_t s, output res_t o);
        int fw = 0;
        int dw = 0;
        o.cyc = -1; o.nret = 0; o.ireq = 0; o.dreq = 0;
        o.rwe = 1'b0; o.wbs = 1'b0; o.halted = 1'b0;
        o.pc = 32'h0; o.ir = 32'h0; o.ir0 = o_instruction;
        i_imem_data = s.instr; i_branch_condition = s.br; i_immediate = s.imm;
        i_destination_register_write_enable = s.we; i_memory_write_enable = s.mwe;
        i_illegal = s.ill; i_alu_zero = s.zero;
        for (int c = 1; c <= 40; c++) begin
            i_imem_ready = o_imem_request && fw >= s.iw;
            i_dmem_ready = o_dmem_request && dw >= s.dw;
            if (o_imem_request) begin fw++; o.ireq++; end
            if (o_dmem_request) begin dw++; o.dreq++; end
            if (o_retired) begin o.nret++; o.cyc = c; o.ir = o_instruction; end
            o.rwe = o.rwe | o_register_write_enable;
            o.wbs = o.wbs | o_writeback_select;
            if (o_halted) begin
                o.halted = 1'b1; o.cyc = c; o.pc = o_pc; o.ir = o_instruction;
                break;
            end
            step();
            if (o.nret > 0) begin
                o.pc = o_pc;
                break;
            end
        end
        i_imem_ready = 1'b0; i_dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_imem_request !== 1'b1) begin errors++; $display("FAIL reset_imem_request got %b want 1", o_imem_request); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 00000000", o_pc); end
        checks++; if (o_instruction !== NOP) begin errors++; $display("FAIL reset_ir got %h want %h", o_instruction, NOP); end
        checks++;
        if ({o_halted, o_retired, o_dmem_request, o_register_write_enable} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {o_halted, o_retired, o_dmem_request, o_register_write_enable});
        end
    endtask

    task automatic test_addi();
        res_t o, e;
        sb.push_back('{4, 1, 1, 0, 1'b1, 1'b0, 1'b0, 32'h4, ADDI, NOP});
        run_instr(mk(ADDI, BRANCH_NONE, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0), o);
        e = sb.pop_front();
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL addi_cycle got %0d want %0d", o.cyc, e.cyc); end
        checks++; if (o.nret !== e.nret) begin errors++; $display("FAIL addi_retired got %0d want %0d", o.nret, e.nret); end
        checks++; if (o.rwe !== e.rwe) begin errors++; $display("FAIL addi_rwe got %b want %b", o.rwe, e.rwe); end
        checks++; if (o.pc !== e.pc) begin errors++; $display("FAIL addi_pc got %h want %h", o.pc, e.pc); end
        checks++; if (o.ir !== e.ir) begin errors++; $display("FAIL addi_ir got %h want %h", o.ir, e.ir); end
        checks++; if (o.ir0 !== e.ir0) begin errors++; $display("FAIL addi_ir0 got %h want %h", o.ir0, e.ir0); end
    endtask

    task automatic test_fetch_wait();
        res_t o, e;
        sb.push_back('{7, 1, 4, 0, 1'b1, 1'b0, 1'b0, 32'h8, ADD2, ADDI});
        run_instr(mk(ADD2, BRANCH_NONE, 32'd10, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0), o);
        e = sb.pop_front();
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL wait_cycle got %0d want %0d", o.cyc, e.cyc); end
        checks++; if (o.ireq !== e.ireq) begin errors++; $display("FAIL wait_imem_request got %0d want %0d", o.ireq, e.ireq); end
        checks++; if (o.ir0 !== e.ir0) begin errors++; $display("FAIL wait_ir_held got %h want %h", o.ir0, e.ir0); end
        checks++; if (o.ir !== e.ir) begin errors++; $display("FAIL wait_ir got %h want %h", o.ir, e.ir); end
        checks++; if (o.pc !== e.pc) begin errors++; $display("FAIL wait_pc got %h want %h", o.pc, e.pc); end
    endtask

    task automatic test_bne();
        stim_t st[4];
        res_t  o, e;
        st[0] = mk(JAL, BRANCH_JUMP, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        st[1] = mk(BNE, BRANCH_NE, 32'hffff_fff8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        st[2] = mk(JAL, BRANCH_JUMP, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        st[3] = mk(BNE, BRANCH_NE, 32'hffff_fff8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        sb.push_back('{4, 1, 1, 0, 1'b1, 1'b1, 1'b0, 32'h10, JAL, ADD2});
        sb.push_back('{4, 1, 1, 0, 1'b0, 1'b0, 1'b0, 32'h08, BNE, JAL});
        sb.push_back('{4, 1, 1, 0, 1'b1, 1'b1, 1'b0, 32'h10, JAL, BNE});
        sb.push_back('{4, 1, 1, 0, 1'b0, 1'b0, 1'b0, 32'h14, BNE, JAL});
        for (int i = 0; i < 4; i++) begin
            run_instr(st[i], o);
            e = sb.pop_front();
            checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL bne%0d_cycle got %0d want %0d", i, o.cyc, e.cyc); end
            checks++; if (o.pc !== e.pc) begin errors++; $display("FAIL bne%0d_pc got %h want %h", i, o.pc, e.pc); end
            checks++; if (o.rwe !== e.rwe) begin errors++; $display("FAIL bne%0d_rwe got %b want %b", i, o.rwe, e.rwe); end
        end
    endtask

    task automatic test_jal();
        stim_t st[4];
        res_t  o, e;
        st[0] = mk(JAL, BRANCH_JUMP, 32'h0000_000c, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        st[1] = mk(JAL, BRANCH_JUMP, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        st[2] = mk(JAL, BRANCH_JUMP, 32'hffff_ff00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        st[3] = mk(JAL, BRANCH_JUMP, 32'h0000_0102, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        sb.push_back('{4, 1, 1, 0, 1'b1, 1'b1, 1'b0, 32'h020, JAL, BNE});
        sb.push_back('{4, 1, 1, 0, 1'b1, 1'b1, 1'b0, 32'h120, JAL, JAL});
        sb.push_back('{4, 1, 1, 0, 1'b1, 1'b1, 1'b0, 32'h020, JAL, JAL});
        sb.push_back('{5, 0, 1, 0, 1'b0, 1'b1, 1'b1, 32'h020, JAL, JAL});
        for (int i = 0; i < 4; i++) begin
            run_instr(st[i], o);
            e = sb.pop_front();
            checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL jal%0d_cycle got %0d want %0d", i, o.cyc, e.cyc); end
            checks++; if (o.pc !== e.pc) begin errors++; $display("FAIL jal%0d_pc got %h want %h", i, o.pc, e.pc); end
            checks++; if (o.nret !== e.nret) begin errors++; $display("FAIL jal%0d_retired got %0d want %0d", i, o.nret, e.nret); end
            checks++; if (o.halted !== e.halted) begin errors++; $display("FAIL jal%0d_halted got %b want %b", i, o.halted, e.halted); end
            checks++; if (o.rwe !== e.rwe) begin errors++; $display("FAIL jal%0d_rwe got %b want %b", i, o.rwe, e.rwe); end
            checks++; if (o.wbs !== e.wbs) begin errors++; $display("FAIL jal%0d_wbsel got %b want %b", i, o.wbs, e.wbs); end
        end
        i_imem_ready = 1'b1; i_dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({o_halted, o_imem_request, o_dmem_request, o_register_write_enable, o_retired} !== 5'b10000 || o_pc !== 32'h20) begin
                errors++;
                $display("FAIL halt_absorb%0d got flags %b pc %h want 10000 pc 00000020", i,
                         {o_halted, o_imem_request, o_dmem_request, o_register_write_enable, o_retired}, o_pc);
            end
        end
        i_imem_ready = 1'b0; i_dmem_ready = 1'b0;
    endtask

    task automatic test_store();
        res_t o, e;
        do_reset();
        sb.push_back('{7, 1, 1, 3, 1'b0, 1'b0, 1'b0, 32'h4, SW, NOP});
        run_instr(mk(SW, BRANCH_NONE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2), o);
        e = sb.pop_front();
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL store_cycle got %0d want %0d", o.cyc, e.cyc); end
        checks++; if (o.dreq !== e.dreq) begin errors++; $display("FAIL store_dmem_request got %0d want %0d", o.dreq, e.dreq); end
        checks++; if (o.rwe !== e.rwe) begin errors++; $display("FAIL store_rwe got %b want %b", o.rwe, e.rwe); end
        checks++; if (o.pc !== e.pc) begin errors++; $display("FAIL store_pc got %h want %h", o.pc, e.pc); end
    endtask

    task automatic test_illegal();
        res_t o, e;
        sb.push_back('{3, 0, 1, 0, 1'b0, 1'b0, 1'b1, 32'h4, BAD, SW});
        run_instr(mk(BAD, BRANCH_NONE, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0), o);
        e = sb.pop_front();
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL illegal_halt_cycle got %0d want %0d", o.cyc, e.cyc); end
        checks++; if (o.nret !== e.nret || o.rwe !== e.rwe) begin errors++; $display("FAIL illegal_retire got %0d/%b want %0d/%b", o.nret, o.rwe, e.nret, e.rwe); end
        checks++; if (o.pc !== e.pc) begin errors++; $display("FAIL illegal_pc got %h want %h", o.pc, e.pc); end
        i_illegal = 1'b0;
        do_reset();
        checks++;
        if ({o_halted, o_imem_request} !== 2'b01 || o_pc !== 32'h0) begin
            errors++; $display("FAIL halt_reset got halted/req %b pc %h want 01 pc 00000000", {o_halted, o_imem_request}, o_pc);
        end
    endtask

    task automatic test_reset_mid();
        res_t o, e;
        sb.push_back('{4, 1, 1, 0, 1'b1, 1'b0, 1'b0, 32'h4, ADDI, NOP});
        run_instr(mk(ADDI, BRANCH_NONE, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0), o);
        e = sb.pop_front();
        checks++; if (o.pc !== e.pc) begin errors++; $display("FAIL mid_setup_pc got %h want %h", o.pc, e.pc); end
        i_imem_data = SW; i_memory_write_enable = 1'b1; i_destination_register_write_enable = 1'b0;
        i_imem_ready = 1'b1;
        step();
        i_imem_ready = 1'b0;
        step();
        step();
        checks++; if (o_dmem_request !== 1'b1) begin errors++; $display("FAIL mid_in_memory got %b want 1", o_dmem_request); end
        i_reset = 1'b1; i_dmem_ready = 1'b1;
        step();
        i_reset = 1'b0; i_dmem_ready = 1'b0;
        checks++;
        if ({o_dmem_request, o_imem_request} !== 2'b01 || o_pc !== 32'h0) begin
            errors++; $display("FAIL mid_reset got dreq/ireq %b pc %h want 01 pc 00000000", {o_dmem_request, o_imem_request}, o_pc);
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[4];
        res_t  o, e;
        st[0] = mk(ADDI, BRANCH_NONE, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        st[1] = mk(SW, BRANCH_NONE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        st[2] = mk(BNE, BRANCH_NE, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        st[3] = mk(JAL, BRANCH_JUMP, 32'hffff_ffb8, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        sb.push_back('{4, 1, 1, 0, 1'b1, 1'b0, 1'b0, 32'h04, ADDI, NOP});
        sb.push_back('{5, 1, 1, 1, 1'b0, 1'b0, 1'b0, 32'h08, SW, ADDI});
        sb.push_back('{4, 1, 1, 0, 1'b0, 1'b0, 1'b0, 32'h48, BNE, SW});
        sb.push_back('{4, 1, 1, 0, 1'b1, 1'b1, 1'b0, 32'h00, JAL, BNE});
        for (int i = 0; i < 4; i++) begin
            run_instr(st[i], o);
            e = sb.pop_front();
            checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL b2b%0d_cycle got %0d want %0d", i, o.cyc, e.cyc); end
            checks++; if (o.pc !== e.pc) begin errors++; $display("FAIL b2b%0d_pc got %h want %h", i, o.pc, e.pc); end
            checks++; if (o.rwe !== e.rwe) begin errors++; $display("FAIL b2b%0d_rwe got %b want %b", i, o.rwe, e.rwe); end
            checks++; if (o.dreq !== e.dreq) begin errors++; $display("FAIL b2b%0d_dreq got %0d want %0d", i, o.dreq, e.dreq); end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_fetch_wait();
        test_bne();
        test_jal();
        test_store();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
